// File: rtl/idecode.sv
// Pipeline decode stage: register file with write-through bypass, opcode decode, ID/EX latch.
// Latency one cycle from IF_ID_* to ID_EX_*; no stall or backpressure, taken branch inserts a control bubble.
module idecode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_rd,
  input  logic [31:0] MEM_WB_wdata,
  output logic [1:0]  ID_EX_wb,
  output logic [2:0]  ID_EX_m,
  output logic [3:0]  ID_EX_ex,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511
);

  logic [31:0] r_regs [32];

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic        w_wr_en;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_sign_ext;
  logic [1:0]  w_wb;
  logic [2:0]  w_m;
  logic [3:0]  w_ex;

  assign w_rs       = IF_ID_instr[25:21];
  assign w_rt       = IF_ID_instr[20:16];
  assign w_wr_en    = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0);
  assign w_sign_ext = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[MEM_WB_rd] <= MEM_WB_wdata;
    end
  end

  // Register 0 reads as zero; a same-cycle writeback is forwarded to the readers.
  always_comb begin
    w_rd1 = r_regs[w_rs];
    w_rd2 = r_regs[w_rt];
    if (w_wr_en && (MEM_WB_rd == w_rs)) w_rd1 = MEM_WB_wdata;
    if (w_wr_en && (MEM_WB_rd == w_rt)) w_rd2 = MEM_WB_wdata;
    if (w_rs == 5'd0) w_rd1 = '0;
    if (w_rt == 5'd0) w_rd2 = '0;
  end

  always_comb begin
    w_wb = 2'b00;
    w_m  = 3'b000;
    w_ex = 4'b0000;
    case (IF_ID_instr[31:26])
      6'h00: begin w_wb = 2'b10; w_m = 3'b000; w_ex = 4'b1100; end
      6'h23: begin w_wb = 2'b11; w_m = 3'b010; w_ex = 4'b0001; end
      6'h2B: begin w_wb = 2'b00; w_m = 3'b001; w_ex = 4'b0001; end
      6'h04: begin w_wb = 2'b00; w_m = 3'b100; w_ex = 4'b0010; end
      default: begin w_wb = 2'b00; w_m = 3'b000; w_ex = 4'b0000; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_wb         <= '0;
      ID_EX_m          <= '0;
      ID_EX_ex         <= '0;
      ID_EX_npc        <= '0;
      ID_EX_readdat1   <= '0;
      ID_EX_readdat2   <= '0;
      ID_EX_sign_ext   <= '0;
      ID_EX_instr_2016 <= '0;
      ID_EX_instr_1511 <= '0;
    end else begin
      // A taken branch squashes only the control fields; data still flows.
      ID_EX_wb         <= EX_MEM_PCSrc ? 2'b00   : w_wb;
      ID_EX_m          <= EX_MEM_PCSrc ? 3'b000  : w_m;
      ID_EX_ex         <= EX_MEM_PCSrc ? 4'b0000 : w_ex;
      ID_EX_npc        <= IF_ID_npc;
      ID_EX_readdat1   <= w_rd1;
      ID_EX_readdat2   <= w_rd2;
      ID_EX_sign_ext   <= w_sign_ext;
      ID_EX_instr_2016 <= IF_ID_instr[20:16];
      ID_EX_instr_1511 <= IF_ID_instr[15:11];
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Directed and randomized checks of idecode against a behavioural register-file/decode model.
module tb_idecode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_npc;
  logic        EX_MEM_PCSrc;
  logic        MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_wdata;
  logic [1:0]  ID_EX_wb;
  logic [2:0]  ID_EX_m;
  logic [3:0]  ID_EX_ex;
  logic [31:0] ID_EX_npc;
  logic [31:0] ID_EX_readdat1;
  logic [31:0] ID_EX_readdat2;
  logic [31:0] ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016;
  logic [4:0]  ID_EX_instr_1511;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_regs [32];

  idecode dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_instr(IF_ID_instr), .IF_ID_npc(IF_ID_npc), .EX_MEM_PCSrc(EX_MEM_PCSrc),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .MEM_WB_wdata(MEM_WB_wdata),
    .ID_EX_wb(ID_EX_wb), .ID_EX_m(ID_EX_m), .ID_EX_ex(ID_EX_ex), .ID_EX_npc(ID_EX_npc),
    .ID_EX_readdat1(ID_EX_readdat1), .ID_EX_readdat2(ID_EX_readdat2),
    .ID_EX_sign_ext(ID_EX_sign_ext), .ID_EX_instr_2016(ID_EX_instr_2016),
    .ID_EX_instr_1511(ID_EX_instr_1511)
  );

  always #5 clk = ~clk;

  // Control word {wb, m, ex} for each opcode of the instruction table.
  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (MEM_WB_RegWrite && MEM_WB_rd == a) return MEM_WB_wdata;
    return m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb"},  {30'd0, ID_EX_wb}, 32'd0);
    chk({tag, "_m"},   {29'd0, ID_EX_m}, 32'd0);
    chk({tag, "_ex"},  {28'd0, ID_EX_ex}, 32'd0);
    chk({tag, "_npc"}, ID_EX_npc, 32'd0);
    chk({tag, "_rd1"}, ID_EX_readdat1, 32'd0);
    chk({tag, "_rd2"}, ID_EX_readdat2, 32'd0);
    chk({tag, "_se"},  ID_EX_sign_ext, 32'd0);
    chk({tag, "_rt"},  {27'd0, ID_EX_instr_2016}, 32'd0);
    chk({tag, "_rd"},  {27'd0, ID_EX_instr_1511}, 32'd0);
  endtask

  // Applies one cycle of inputs, then checks the latched outputs against the model.
  task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic pcsrc,
                       input logic we, input logic [4:0] rd, input logic [31:0] wdata);
    logic [8:0]  e_ctrl;
    logic [31:0] e_rd1, e_rd2, e_se;
    IF_ID_instr     = instr;
    IF_ID_npc       = npc;
    EX_MEM_PCSrc    = pcsrc;
    MEM_WB_RegWrite = we;
    MEM_WB_rd       = rd;
    MEM_WB_wdata    = wdata;
    e_ctrl = pcsrc ? 9'd0 : ctrl_of(instr[31:26]);
    e_rd1  = model_read(instr[25:21]);
    e_rd2  = model_read(instr[20:16]);
    e_se   = 32'($signed(instr[15:0]));
    @(posedge clk);
    #1;
    chk("wb",   {30'd0, ID_EX_wb}, {30'd0, e_ctrl[8:7]});
    chk("m",    {29'd0, ID_EX_m},  {29'd0, e_ctrl[6:4]});
    chk("ex",   {28'd0, ID_EX_ex}, {28'd0, e_ctrl[3:0]});
    chk("npc",  ID_EX_npc, npc);
    chk("rd1",  ID_EX_readdat1, e_rd1);
    chk("rd2",  ID_EX_readdat2, e_rd2);
    chk("sext", ID_EX_sign_ext, e_se);
    chk("i2016", {27'd0, ID_EX_instr_2016}, {27'd0, instr[20:16]});
    chk("i1511", {27'd0, ID_EX_instr_1511}, {27'd0, instr[15:11]});
    if (we && rd != 5'd0) m_regs[rd] = wdata;
  endtask

  initial begin
    logic [31:0] instr;
    logic [5:0]  op;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    rst_n = 1'b1;
    IF_ID_instr = 32'd0; IF_ID_npc = 32'd0; EX_MEM_PCSrc = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_rd = 5'd0; MEM_WB_wdata = 32'd0;
    #1 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // write r5 then read it through an add
    drive(32'hFC00_0000, 32'h4, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    drive(32'h00A0_1020, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("add_rd1", ID_EX_readdat1, 32'h0000_00AA);
    chk("add_rd2", ID_EX_readdat2, 32'd0);
    chk("add_ctl", {23'd0, ID_EX_wb, ID_EX_m, ID_EX_ex}, {23'd0, 9'b10_000_1100});
    chk("add_1511", {27'd0, ID_EX_instr_1511}, 32'd2);

    drive(32'h8CA2_FFFC, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lw_se",  ID_EX_sign_ext, 32'hFFFF_FFFC);
    chk("lw_ctl", {23'd0, ID_EX_wb, ID_EX_m, ID_EX_ex}, {23'd0, 9'b11_010_0001});
    chk("lw_2016", {27'd0, ID_EX_instr_2016}, 32'd2);
    chk("lw_npc", ID_EX_npc, 32'h8);

    // same-cycle writeback to rs is forwarded into the latch
    drive(32'h00A0_1020, 32'hC, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    chk("byp_rd1", ID_EX_readdat1, 32'h0000_1234);

    drive(32'hFC00_0000, 32'h10, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    drive(32'h0000_0000, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("r0_rd1", ID_EX_readdat1, 32'd0);

    // flush plus simultaneous writeback: both must take effect
    drive(32'h10A2_0003, 32'h18, 1'b1, 1'b1, 5'd3, 32'hCAFE_0003);
    chk("fl_ctl", {23'd0, ID_EX_wb, ID_EX_m, ID_EX_ex}, 32'd0);
    chk("fl_se",  ID_EX_sign_ext, 32'h3);
    drive(32'h10A2_0003, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq_m",  {29'd0, ID_EX_m}, 32'b100);
    chk("beq_ex", {28'd0, ID_EX_ex}, 32'b0010);
    drive(32'h0060_0000, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("fl_wr", ID_EX_readdat1, 32'hCAFE_0003);

    // randomized traffic, small register range to provoke bypass hits
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        default: op = 6'($urandom);
      endcase
      instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      drive(instr, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom);
    end

    // mid-run reset with a writeback pending in the same cycle
    IF_ID_instr = 32'h00E7_0000; MEM_WB_RegWrite = 1'b1; MEM_WB_rd = 5'd7;
    MEM_WB_wdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("arst");
    @(posedge clk);
    #1 chk_all_zero("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int r = 1; r < 32; r++) begin
      drive({6'h00, 5'(r), 5'(r), 16'h0}, 32'(r), 1'b0, 1'b0, 5'd0, 32'd0);
      chk("post_rst_rd1", ID_EX_readdat1, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 The module SHALL have port IF_ID_instr, input, 32 bits: fetched instruction from the IF/ID latch.
REQ-003 The module SHALL have port IF_ID_npc, input, 32 bits: PC+4 from the IF/ID latch.
REQ-004 The module SHALL have port EX_MEM_PCSrc, input, 1 bit: taken-branch flush request, the same signal that drives ifetch.
REQ-005 The module SHALL have ports MEM_WB_RegWrite (input, 1), MEM_WB_rd (input, 5) and MEM_WB_wdata (input, 32): the writeback port.
REQ-006 The module SHALL have port ID_EX_wb, output, 2 bits, encoded {RegWrite, MemtoReg}.
REQ-007 The module SHALL have port ID_EX_m, output, 3 bits, encoded {Branch, MemRead, MemWrite}.
REQ-008 The module SHALL have port ID_EX_ex, output, 4 bits, encoded {RegDst, ALUOp[1:0], ALUSrc}.
REQ-009 The module SHALL have outputs ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2 and ID_EX_sign_ext, each 32 bits.
REQ-010 The module SHALL have outputs ID_EX_instr_2016 and ID_EX_instr_1511, each 5 bits.

Function
REQ-011 The module SHALL contain a 32x32 register file with two combinational read ports (rs = instr[25:21], rt = instr[20:16]) and one write port.
REQ-012 The register file write SHALL occur on the rising edge of clk when MEM_WB_RegWrite=1 and MEM_WB_rd!=0.
REQ-013 Register 0 SHALL always read 0; writes to register 0 SHALL be ignored.
REQ-014 Write-through bypass: when MEM_WB_RegWrite=1, MEM_WB_rd!=0 and MEM_WB_rd equals rs (or rt), the corresponding read value SHALL be MEM_WB_wdata in the same cycle.
REQ-015 The decode SHALL use opcode instr[31:26], producing {wb, m, ex} as follows:
- 0x00 (R-type): wb=10, m=000, ex=1100
- 0x23 (lw): wb=11, m=010, ex=0001
- 0x2B (sw): wb=00, m=001, ex=0001
- 0x04 (beq): wb=00, m=100, ex=0010
- any other opcode: all zero (nop)
REQ-016 ID_EX_sign_ext SHALL equal instr[15:0] sign-extended from bit 15.
REQ-017 All ID_EX_* outputs SHALL be registered, loading on every rising clk edge with a latency of one cycle from IF_ID_* inputs; there is no stall or enable.
REQ-018 When EX_MEM_PCSrc=1 at a clock edge, ID_EX_wb, ID_EX_m and ID_EX_ex SHALL load zero (bubble), while the data fields load normally.
REQ-019 If a writeback and a read of the same register occur in the same cycle, the latched readdat SHALL hold the new value (per REQ-014).
REQ-020 If a writeback and a flush occur in the same cycle, both SHALL take effect independently.

Reset
REQ-021 While rst_n=0, all ID_EX_* outputs SHALL be 0 and all 32 registers SHALL be cleared to 0, immediately and without waiting for clk.
REQ-022 Reset asserted mid-operation SHALL discard any pending writeback in that cycle.
REQ-023 The first rising edge after rst_n deasserts SHALL perform a normal load.

Verification
REQ-024 The bench SHALL cover: rst_n=0 pulsed mid-run -> all outputs 0 asynchronously; reading registers 1..31 afterwards returns 0.
REQ-025 The bench SHALL cover: write reg5=0x000000AA, then instr 0x00A01020 (add rs=5, rt=0) -> next cycle readdat1=0xAA, readdat2=0, wb=10, m=000, ex=1100, instr_1511=2.
REQ-026 The bench SHALL cover: instr 0x8CA2FFFC (lw) with npc=0x8 -> sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, instr_2016=2, npc=0x8.
REQ-027 The bench SHALL cover: MEM_WB write rd=5, wdata=0x1234 in the same cycle as an instr with rs=5 -> readdat1=0x1234 after that edge.
REQ-028 The bench SHALL cover: write rd=0, wdata=0xFFFFFFFF, then read rs=0 -> readdat1=0.
REQ-029 The bench SHALL cover: beq 0x10A20003 with EX_MEM_PCSrc=1 -> wb, m and ex all 0, sign_ext=0x3; the same instr with PCSrc=0 -> m=100, ex=0010.
